inst_fetch_queue: RTL and testbench

//  Decoupled fetch queue between the fetch stage (PC register + instruction ROM) and decode.

---
 rtl/inst_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Decoupled fetch queue between fetch (PC + instruction ROM) and decode. It buffers up to
//   DEPTH fetched {pc, inst} pairs so fetch keeps running while decode stalls. It also
//   presents one registered {pc, inst} pair to decode each cycle, in place of a plain IF/ID
//   register.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stall[5:0]          pipeline stall vector; only stall[1] (IF/ID) and stall[2] (ID) matter
//   flush               exception flush, discards everything
//   redirect_i          branch taken in ID; keep only the delay-slot entry
//   if_valid_i/pc/inst  entry offered by fetch
//   if_ready_o          queue has room (registered state only)
//   id_valid_o/pc/inst  registered entry presented to decode
//   count_o             number of queued entries, 0..DEPTH
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    stall,
   input  logic          flush,
   input  logic          redirect_i,
   input  logic          if_valid_i,
   input  logic [DW-1:0] if_pc_i,
   input  logic [DW-1:0] if_inst_i,
   output logic          if_ready_o,
   output logic          id_valid_o,
   output logic [DW-1:0] id_pc_o,
   output logic [DW-1:0] id_inst_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   logic [DW-1:0] pc_mem_q   [DEPTH];
   logic [DW-1:0] pc_mem_d   [DEPTH];
   logic [DW-1:0] inst_mem_q [DEPTH];
   logic [DW-1:0] inst_mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          id_valid_q, id_valid_d;
   logic [DW-1:0] id_pc_q, id_pc_d;
   logic [DW-1:0] id_inst_q, id_inst_d;
   logic          push, pop;
   logic          unused_stall;

   assign unused_stall = ^{stall[5:3], stall[0]};

   // Ready depends on the registered count only, so it has no path from the inputs.
   assign if_ready_o = (count_q < CntFull);
   assign push       = if_valid_i && if_ready_o && !flush;
   assign pop        = !stall[1] && (count_q != '0) && !flush;

   always_comb begin
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      // Writing the slot is harmless even when the push is later discarded: the slot at
      // wr_ptr is never live while the queue is not full.
      if (push) begin
         pc_mem_d[wr_ptr_q]   = if_pc_i;
         inst_mem_d[wr_ptr_q] = if_inst_i;
      end
   end

   always_comb begin
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      if (flush) begin
         id_valid_d = 1'b0;
      end else if (stall[1] && !stall[2]) begin
         id_valid_d = 1'b0;              // decode advances while fetch is held: bubble
      end else if (stall[1]) begin
         id_valid_d = id_valid_q;
         id_pc_d    = id_pc_q;
         id_inst_d  = id_inst_q;
      end else if (count_q != '0) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc_mem_q[rd_ptr_q];
         id_inst_d  = inst_mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (redirect_i) begin
         // Keep only the oldest in-flight entry (the delay slot).
         if (count_q != '0) begin
            wr_ptr_d = rd_ptr_q + 1'b1;
            if (pop) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               count_d  = '0;
            end else begin
               count_d  = (AW+1)'(1);
            end
         end else if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = (AW+1)'(1);
         end else begin
            count_d  = '0;
         end
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (!push && pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
   end

   assign id_valid_o = id_valid_q;
   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign count_o    = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: inputs change 1ns after each rising edge, and outputs
// are checked at the same point, after the edge has taken effect.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        redirect_i;
   logic        if_valid_i;
   logic [31:0] if_pc_i;
   logic [31:0] if_inst_i;
   logic        if_ready_o;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic [2:0]  count_o;

   int tests = 0;
   int fails = 0;

   localparam logic [5:0] StHold   = 6'b000111;
   localparam logic [5:0] StBubble = 6'b000010;
   localparam logic [5:0] StRun    = 6'b000000;

   inst_fetch_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .redirect_i (redirect_i),
      .if_valid_i (if_valid_i),
      .if_pc_i    (if_pc_i),
      .if_inst_i  (if_inst_i),
      .if_ready_o (if_ready_o),
      .id_valid_o (id_valid_o),
      .id_pc_o    (id_pc_o),
      .id_inst_o  (id_inst_o),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic v, input logic [31:0] pc);
      if_valid_i = v;
      if_pc_i    = pc;
      if_inst_i  = inst_of(pc);
   endtask

   task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] cnt);
      chk({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, v});
      chk({tag, ".pc"}, id_pc_o, pc);
      chk({tag, ".inst"}, id_inst_o, v ? inst_of(pc) : 32'h0);
      chk({tag, ".count"}, {29'b0, count_o}, cnt);
   endtask

   initial begin
      rst = 1'b1; stall = StRun; flush = 1'b0; redirect_i = 1'b0;
      offer(1'b0, 32'h0);
      #1;
      // 1 reset
      step(); step();
      chk_id("reset", 1'b0, 32'h0, 0);
      chk("reset.ready", {31'b0, if_ready_o}, 32'd1);
      rst = 1'b0;

      // 2 fill under full stall, overflow dropped, then drain in order
      stall = StHold;
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 32'h3000_0000 + 32'(4 * i));
         step();
         chk("fill.count", {29'b0, count_o}, 32'(i + 1));
      end
      chk("fill.ready", {31'b0, if_ready_o}, 32'd0);
      offer(1'b1, 32'h3000_0010);
      step();
      chk_id("overflow", 1'b0, 32'h0, 4);
      offer(1'b0, 32'h0);
      stall = StRun;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_id("drain", 1'b1, 32'h3000_0000 + 32'(4 * i), 32'(3 - i));
      end
      step();
      chk_id("drain.empty", 1'b0, 32'h0, 0);

      // 3 flush with a same-cycle push
      stall = StHold;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 32'h3000_0040 + 32'(4 * i));
         step();
      end
      stall = StRun;
      offer(1'b1, 32'h3000_004C);
      step();
      chk_id("preflush", 1'b1, 32'h3000_0040, 3);
      offer(1'b1, 32'h3000_0050);
      flush = 1'b1;
      step();
      chk_id("flush", 1'b0, 32'h0, 0);
      flush = 1'b0;
      offer(1'b0, 32'h0);
      step();
      chk_id("postflush", 1'b0, 32'h0, 0);

      // 4 redirect, head popped the same cycle
      stall = StHold;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 32'h3000_0020 + 32'(4 * i));
         step();
      end
      offer(1'b0, 32'h0);
      stall = StRun;
      redirect_i = 1'b1;
      step();
      chk_id("redir.pop", 1'b1, 32'h3000_0020, 0);
      redirect_i = 1'b0;
      step();
      chk_id("redir.pop.after", 1'b0, 32'h0, 0);

      // 4b redirect while held: head kept, popped next
      stall = StHold;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 32'h3000_0020 + 32'(4 * i));
         step();
      end
      offer(1'b0, 32'h0);
      redirect_i = 1'b1;
      step();
      chk_id("redir.hold", 1'b0, 32'h0, 1);
      redirect_i = 1'b0;
      stall = StRun;
      step();
      chk_id("redir.hold.pop", 1'b1, 32'h3000_0020, 0);
      step();
      chk_id("redir.hold.after", 1'b0, 32'h0, 0);

      // 4c redirect with empty queue keeps the same-cycle push
      redirect_i = 1'b1;
      offer(1'b1, 32'h3000_0060);
      step();
      chk_id("redir.empty", 1'b0, 32'h0, 1);
      redirect_i = 1'b0;
      offer(1'b0, 32'h0);
      step();
      chk_id("redir.empty.pop", 1'b1, 32'h3000_0060, 0);

      // 5 bubble rules
      stall = StHold;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 32'h3000_0070 + 32'(4 * i));
         step();
      end
      offer(1'b0, 32'h0);
      stall = StRun;
      step();
      chk_id("bub.first", 1'b1, 32'h3000_0070, 2);
      stall = StBubble;
      step();
      chk_id("bub.stall1", 1'b0, 32'h0, 2);
      stall = StRun;
      step();
      chk_id("bub.next0", 1'b1, 32'h3000_0074, 1);
      step();
      chk_id("bub.next1", 1'b1, 32'h3000_0078, 0);
      step();
      chk_id("bub.empty", 1'b0, 32'h0, 0);

      // 6 wrap-around: push every cycle, pop every cycle
      for (int k = 0; k < 10; k++) begin
         offer(1'b1, 32'h3000_0080 + 32'(4 * k));
         step();
         chk("wrap.count", {31'b0, (count_o <= 3'd4)}, 32'd1);
         if (k == 0) chk_id("wrap.first", 1'b0, 32'h0, 1);
         else        chk_id("wrap", 1'b1, 32'h3000_0080 + 32'(4 * (k - 1)), 1);
      end
      offer(1'b0, 32'h0);
      step();
      chk_id("wrap.last", 1'b1, 32'h3000_00A4, 0);

      // mid-operation reset discards everything
      stall = StHold;
      offer(1'b1, 32'h3000_00C0);
      step(); step();
      rst = 1'b1;
      offer(1'b0, 32'h0);
      step();
      rst = 1'b0;
      chk_id("midreset", 1'b0, 32'h0, 0);
      chk("midreset.ready", {31'b0, if_ready_o}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
